// File: rtl/store_data_unit_pkg.sv
// store_data_unit_pkg: size encodings, FSM state type and the buffered store entry.
package store_data_unit_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;
  typedef enum logic {IDLE, ISSUE} state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;
endpackage

// File: rtl/store_data_unit_align.sv
// store_align: lane replication and byte-enable generation; MISALIGN_CHECK_EN flags misaligned half/word.
module store_align
  import store_data_unit_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        bad_o
);
  logic mis;
  assign addr_o  = {addr_i[31:2], 2'b00};
  assign wdata_o = size_i == SZ_BYTE ? {4{data_i[7:0]}} : size_i == SZ_HALF ? {2{data_i[15:0]}} : data_i;
  assign be_o    = size_i == SZ_BYTE ? 4'b0001 << addr_i[1:0] : size_i == SZ_HALF ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef MISALIGN_CHECK_EN
  assign mis = (size_i == SZ_HALF && addr_i[0]) || (size_i == SZ_WORD && addr_i[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign bad_o = size_i == SZ_RSVD || mis;
endmodule

// File: rtl/store_data_unit.sv
// store_data_unit: 2-entry store FIFO feeding a memory write port with ack timeout; MISALIGN_CHECK_EN enables misalign errors.
module store_data_unit
  import store_data_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        busy,
  output logic        err
);
  logic [1:0]  cnt_q, cnt_d;
  entry_t      s0_q, s1_q, s0_d, s1_d, new_e;
  state_e      state_q;
  logic [9:0]  tmo_q;
  logic        err_q, bad, acc, push, pop, tmo_hit;
  logic [31:0] al_addr, al_wdata;
  logic [3:0]  al_be;
  store_align u_align (
    .addr_i (st_addr),
    .data_i (st_data),
    .size_i (st_size),
    .addr_o (al_addr),
    .wdata_o(al_wdata),
    .be_o   (al_be),
    .bad_o  (bad)
  );
  assign new_e     = '{addr: al_addr, wdata: al_wdata, be: al_be};
  assign st_ready  = cnt_q != 2'd2;
  assign acc       = st_valid && st_ready;
  assign push      = acc && !bad;
  assign mem_we    = state_q == ISSUE;
  assign tmo_hit   = mem_we && !mem_ack && tmo_q == 10'(ACK_TIMEOUT - 1);
  assign pop       = mem_we && (mem_ack || tmo_hit);
  assign busy      = cnt_q != 2'd0;
  assign err       = err_q;
  assign mem_addr  = s0_q.addr;
  assign mem_wdata = s0_q.wdata;
  assign mem_be    = s0_q.be;
  // slot 0 is the head; it is only overwritten by a new or shifted entry, so it holds the last write when idle
  always_comb begin
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    s0_d  = push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1)) ? new_e : (pop && cnt_q == 2'd2 ? s1_q : s0_q);
    s1_d  = push && cnt_q == 2'd1 && !pop ? new_e : s1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= cnt_d != 2'd0 ? ISSUE : IDLE;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      tmo_q   <= (pop || !mem_we) ? '0 : tmo_q + 10'd1;
      err_q   <= (acc && bad) || (pop && !mem_ack);
    end
  end
endmodule

// File: tb/tb_store_data_unit.sv
// tb_store_data_unit: directed checks of store_data_unit with ACK_TIMEOUT=4.
module tb_store_data_unit;
  logic        clk = 0, reset = 1, st_valid = 0, mem_ack = 0;
  logic [31:0] st_addr = 0, st_data = 0;
  logic [1:0]  st_size = 0;
  logic        st_ready, mem_we, busy, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int total = 0, bad = 0;
  int we_cnt, err_cnt;
  store_data_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(st_ready), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", 32'(mem_be), 0);
    reset = 0;
    tick;
    // byte store, ack in third cycle
    offer(32'h1003, 32'hAB, 2'b00);
    tick;
    st_valid = 0;
    chk("b_we1", 32'(mem_we), 1);
    chk("b_addr", mem_addr, 32'h1000);
    chk("b_wdata", mem_wdata, 32'hABABABAB);
    chk("b_be", 32'(mem_be), 32'h8);
    chk("b_busy", 32'(busy), 1);
    tick;
    chk("b_we2", 32'(mem_we), 1);
    chk("b_stable", mem_wdata, 32'hABABABAB);
    tick;
    chk("b_we3", 32'(mem_we), 1);
    mem_ack = 1;
    tick;
    mem_ack = 0;
    chk("b_we_off", 32'(mem_we), 0);
    chk("b_busy_off", 32'(busy), 0);
    chk("b_hold", mem_addr, 32'h1000);
    // half then word, ack held high (ack while idle ignored)
    mem_ack = 1;
    offer(32'h2002, 32'h1234, 2'b01);
    tick;
    offer(32'h2004, 32'hDEADBEEF, 2'b10);
    chk("h_we", 32'(mem_we), 1);
    chk("h_addr", mem_addr, 32'h2000);
    chk("h_wdata", mem_wdata, 32'h12341234);
    chk("h_be", 32'(mem_be), 32'hC);
    tick;
    st_valid = 0;
    chk("w_we", 32'(mem_we), 1);
    chk("w_addr", mem_addr, 32'h2004);
    chk("w_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_be", 32'(mem_be), 32'hF);
    tick;
    chk("hw_done", 32'(mem_we), 0);
    mem_ack = 0;
    // backpressure with two buffered entries
    offer(32'h4000, 32'h11111111, 2'b10);
    tick;
    chk("bp_ready1", 32'(st_ready), 1);
    offer(32'h4004, 32'h22222222, 2'b10);
    tick;
    chk("bp_ready2", 32'(st_ready), 0);
    offer(32'h4008, 32'h33333333, 2'b10);
    tick;
    chk("bp_held", 32'(st_ready), 0);
    chk("bp_addrA", mem_addr, 32'h4000);
    mem_ack = 1;
    tick;
    mem_ack = 0;
    chk("bp_addrB", mem_addr, 32'h4004);
    chk("bp_ready3", 32'(st_ready), 1);
    chk("bp_weB", 32'(mem_we), 1);
    tick;
    st_valid = 0;
    chk("bp_fullC", 32'(st_ready), 0);
    mem_ack = 1;
    tick;
    chk("bp_addrC", mem_addr, 32'h4008);
    chk("bp_wdataC", mem_wdata, 32'h33333333);
    tick;
    mem_ack = 0;
    chk("bp_idle", 32'(busy), 0);
    chk("bp_err", 32'(err), 0);
    // timeout: no ack
    offer(32'h5000, 32'h55555555, 2'b10);
    tick;
    st_valid = 0;
    we_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_we) we_cnt++;
      if (err) err_cnt++;
      tick;
    end
    chk("to_we_cycles", 32'(we_cnt), 4);
    chk("to_err_cycles", 32'(err_cnt), 1);
    chk("to_busy", 32'(busy), 0);
    // misaligned word
    offer(32'h3002, 32'hCAFEF00D, 2'b10);
    tick;
    st_valid = 0;
`ifdef MISALIGN_CHECK_EN
    chk("mis_we", 32'(mem_we), 0);
    chk("mis_err", 32'(err), 1);
    chk("mis_busy", 32'(busy), 0);
    tick;
    chk("mis_err_off", 32'(err), 0);
`else
    chk("mis_we", 32'(mem_we), 1);
    chk("mis_addr", mem_addr, 32'h3000);
    chk("mis_be", 32'(mem_be), 32'hF);
    chk("mis_err", 32'(err), 0);
    mem_ack = 1;
    tick;
    mem_ack = 0;
`endif
    // reserved size
    offer(32'h6000, 32'h66666666, 2'b11);
    tick;
    st_valid = 0;
    chk("rsv_err", 32'(err), 1);
    chk("rsv_we", 32'(mem_we), 0);
    chk("rsv_busy", 32'(busy), 0);
    tick;
    chk("rsv_err_off", 32'(err), 0);
    // byte lane 1 and low half
    mem_ack = 1;
    offer(32'h7001, 32'h1C5, 2'b00);
    tick;
    offer(32'h7000, 32'hBEEF, 2'b01);
    chk("l1_be", 32'(mem_be), 32'h2);
    chk("l1_wdata", mem_wdata, 32'hC5C5C5C5);
    tick;
    st_valid = 0;
    chk("lh_be", 32'(mem_be), 32'h3);
    chk("lh_wdata", mem_wdata, 32'hBEEFBEEF);
    tick;
    mem_ack = 0;
    // reset during an in-flight write with a second entry buffered
    offer(32'h8000, 32'h88888888, 2'b10);
    tick;
    offer(32'h8004, 32'h99999999, 2'b10);
    tick;
    st_valid = 0;
    chk("rr_we", 32'(mem_we), 1);
    chk("rr_full", 32'(st_ready), 0);
    reset = 1;
    tick;
    reset = 0;
    chk("rr_we0", 32'(mem_we), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_ready", 32'(st_ready), 1);
    chk("rr_addr", mem_addr, 0);
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (mem_we) we_cnt++;
    end
    chk("rr_no_write", 32'(we_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_data_unit.md
STORE_DATA_UNIT -- requirements
Module: store_data_unit

Interface
REQ-001 Parameter: ACK_TIMEOUT, 255, max cycles mem_we is held without mem_ack before the write is abandoned (range 1..1023).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 st_valid  in  1  CPU store request valid.
REQ-005 st_ready  out  1  unit can accept a store this cycle.
REQ-006 st_addr  in  32  byte address of store.
REQ-007 st_data  in  32  store data, right-justified.
REQ-008 st_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 mem_we  out  1  memory write strobe.
REQ-010 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-011 mem_wdata  out  32  lane-aligned write data.
REQ-012 mem_be  out  4  byte enables, bit i = byte lane i.
REQ-013 mem_ack  in  1  memory accepted the write this cycle.
REQ-014 busy  out  1  high while any store is buffered or in flight.
REQ-015 err  out  1  one-cycle pulse: timeout, reserved size, or misalign.

Function
REQ-016 Store accepted on a rising edge with st_valid && st_ready; accepted store SHALL enter a 2-entry FIFO.
REQ-017 st_ready SHALL equal !full, independent of st_valid and mem_ack; no push when full.
REQ-018 FSM states IDLE and ISSUE: IDLE->ISSUE when FIFO non-empty; ISSUE->ISSUE on ack/timeout with FIFO still non-empty after pop; ISSUE->IDLE when FIFO empties.
REQ-019 Store accepted at edge N into an empty FIFO SHALL drive mem_we=1 from cycle N+1 (one-cycle latency).
REQ-020 In ISSUE, mem_we, mem_addr, mem_wdata, mem_be SHALL stay stable until mem_ack sampled high; entry pops on that edge.
REQ-021 Back-to-back: if a second entry is buffered, mem_we SHALL stay high in the cycle after ack with the next entry's fields (no bubble).
REQ-022 Byte: mem_wdata = st_data[7:0] replicated to all four lanes; mem_be = 1 << addr[1:0].
REQ-023 Half: mem_wdata = st_data[15:0] replicated to both halves; mem_be = addr[1] ? 1100 : 0011.
REQ-024 Word: mem_wdata = st_data; mem_be = 1111.
REQ-025 Reserved size: store accepted, never written, err pulses the cycle after acceptance.
REQ-026 Timeout counter clears on entering each write; at ACK_TIMEOUT cycles without ack the entry SHALL be dropped and err pulse one cycle.
REQ-027 mem_ack while mem_we=0 SHALL be ignored.
REQ-028 busy = FIFO non-empty; mem_we=0 when not in ISSUE; mem_addr/mem_wdata/mem_be hold last value when idle.
REQ-029 Push and pop in the same cycle (FIFO not full) SHALL both take effect; occupancy unchanged.

Reset
REQ-030 reset SHALL flush FIFO, abandon any in-flight write, force IDLE, clear timeout counter.
REQ-031 Reset values: mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0000, busy 0, err 0, st_ready 1; mem_we low in the cycle after reset is sampled.

Configuration
REQ-032 Macro MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 SHALL be accepted, not written, err pulses the cycle after acceptance.
REQ-033 Macro undefined: address bits below the access size SHALL be ignored (half uses addr[1] only, word ignores addr[1:0]); store written normally, no err.

Structure
REQ-034 Shared package SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the FSM state type.
REQ-035 Lane alignment/byte-enable generation SHALL be a combinational sub-module store_align; FIFO and FSM stay in store_data_unit.

Verification
REQ-036 Byte store addr 0x1003 data 0xAB, ack after 2 cycles -> mem_addr 0x1000, mem_wdata 0xABABABAB, mem_be 1000, mem_we high 3 cycles.
REQ-037 Half store addr 0x2002 data 0x1234 then word 0x2004 data 0xDEADBEEF, ack every cycle -> two consecutive mem_we cycles, be 1100 then 1111, no bubble.
REQ-038 Three stores offered, mem_ack held 0 -> st_ready drops after second acceptance, third held off until first ack.
REQ-039 ACK_TIMEOUT=4, no ack -> mem_we high exactly 4 cycles, err one-cycle pulse, entry dropped, busy falls.
REQ-040 Word store to 0x3002 -> with MISALIGN_CHECK_EN: no mem_we, err pulse; without: mem_addr 0x3000, be 1111.
REQ-041 reset asserted while mem_we high with second entry buffered -> next cycle mem_we 0, busy 0, st_ready 1, no later write.
